// File: rtl/my_counter_pkg.sv
// Shared definitions for the presettable binary counter family (up and down variants).
//
// Contents:
//   DefaultWidth / MinWidth / MaxWidth : width constants for counter instances
//   op_e                               : per-edge operation chosen by the priority decode
//   decode_op()                        : LD / CTP / CTT priority decode, common to both counters
package my_counter_pkg;

   localparam int unsigned DefaultWidth = 4;
   localparam int unsigned MinWidth     = 2;
   localparam int unsigned MaxWidth     = 16;

   typedef enum logic [1:0] {
      OpHold  = 2'd0,
      OpLoad  = 2'd1,
      OpCount = 2'd2
   } op_e;

   // Load (active-low) beats count; counting needs both enables.
   function automatic op_e decode_op(input logic ld_n, input logic ctp, input logic ctt);
      op_e op;
      if (!ld_n) begin
         op = OpLoad;
      end else if (ctp && ctt) begin
         op = OpCount;
      end else begin
         op = OpHold;
      end
      return op;
   endfunction

endpackage

// File: rtl/my_down_counter_if.sv
// Control/data bundle for one my_down_counter stage.
//
// Signals:
//   LD  : synchronous parallel load, active-low
//   CTP : count enable P (does not gate Bo)
//   CTT : count enable T (gates Bo, cascade input)
//   D   : parallel load data
//   Q   : registered counter state
//   Bo  : borrow / terminal count, CTT & (Q == 0)
// Modports: master drives controls and observes Q/Bo; slave is the counter.
interface my_down_counter_if #(
   parameter int unsigned WIDTH = my_counter_pkg::DefaultWidth
) ();

   logic             LD;
   logic             CTP;
   logic             CTT;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             Bo;

   modport master (
      output LD, CTP, CTT, D,
      input  Q, Bo
   );

   modport slave (
      input  LD, CTP, CTT, D,
      output Q, Bo
   );

endinterface

// File: rtl/my_down_counter.sv
// Synchronous presettable binary down counter with ripple borrow output.
//
// Ports:
//   CP  : clock, rising-edge active
//   CR  : asynchronous reset, active-high, forces Q to zero
//   bus : my_down_counter_if.slave carrying LD, CTP, CTT, D (in) and Q, Bo (out)
//
// Per-edge priority (CR low): LD=0 loads D; else CTP&CTT decrements; else hold.
// Cascade by feeding Bo of a lower stage into CTT of the next stage.
//
// Build option:
//   MY_DOWN_COUNTER_AUTO_RELOAD_EN : a counting edge at Q==0 reloads D instead of wrapping
//   to all ones, giving a divide-by-(D+1) stage with Bo marking the reload cycle.
module my_down_counter
   import my_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic                 CP,
   input  logic                 CR,
   my_down_counter_if.slave     bus
);

   localparam logic [WIDTH-1:0] QZero = '0;
   localparam logic [WIDTH-1:0] QOnes = '1;

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   op_e              op;

   always_comb begin
      op = decode_op(bus.LD, bus.CTP, bus.CTT);
   end

   // Next-state selection.
   always_comb begin
      q_d = q_q;
      unique case (op)
         OpLoad: begin
            q_d = bus.D;
         end
         OpCount: begin
            if (q_q == QZero) begin
`ifdef MY_DOWN_COUNTER_AUTO_RELOAD_EN
               q_d = bus.D;
`else
               q_d = QOnes;
`endif
            end else begin
               q_d = q_q - 1'b1;
            end
         end
         default: begin
            q_d = q_q;
         end
      endcase
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         q_q <= QZero;
      end else begin
         q_q <= q_d;
      end
   end

   // Borrow is combinational so a cascaded stage sees it in the same cycle.
   always_comb begin
      bus.Q  = q_q;
      bus.Bo = bus.CTT & (q_q == QZero);
   end

endmodule

// File: tb/tb_my_down_counter.sv
module tb_my_down_counter;

   localparam int W = 4;
   localparam int M = 16;

   logic cp;
   logic cr;
   int   total;
   int   bad;
   int   m;        // reference value of the single-stage counter
   int   lo_m;     // reference values of the cascade stages
   int   hi_m;

   my_down_counter_if #(.WIDTH(W)) bus ();
   my_down_counter_if #(.WIDTH(W)) bus_lo ();
   my_down_counter_if #(.WIDTH(W)) bus_hi ();

   my_down_counter #(.WIDTH(W)) u_dut (.CP(cp), .CR(cr), .bus(bus));
   my_down_counter #(.WIDTH(W)) u_lo  (.CP(cp), .CR(cr), .bus(bus_lo));
   my_down_counter #(.WIDTH(W)) u_hi  (.CP(cp), .CR(cr), .bus(bus_hi));

   assign bus_hi.CTT = bus_lo.Bo;

   initial cp = 1'b0;
   always #20 cp = ~cp;

   // Counter rule from the behavioural description, in plain integer arithmetic.
   function automatic int rule(input int q, input bit ld_n, input bit ctp, input bit ctt,
                               input int d);
      if (!ld_n) return d;
      if (ctp && ctt) begin
`ifdef MY_DOWN_COUNTER_AUTO_RELOAD_EN
         if (q == 0) return d;
`endif
         return (q + M - 1) % M;
      end
      return q;
   endfunction

   // Advance both references using the inputs present before the edge, then clock.
   task automatic step();
      bit lo_z;
      lo_z = (lo_m == 0);
      if (cr) begin
         m = 0; lo_m = 0; hi_m = 0;
      end else begin
         m    = rule(m, bus.LD, bus.CTP, bus.CTT, int'(bus.D));
         hi_m = rule(hi_m, bus_hi.LD, bus_hi.CTP, bus_lo.CTT && lo_z, int'(bus_hi.D));
         lo_m = rule(lo_m, bus_lo.LD, bus_lo.CTP, bus_lo.CTT, int'(bus_lo.D));
      end
      @(posedge cp);
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] exp_q;
      bus.LD = 1'b1; bus.CTP = 1'b0; bus.CTT = 1'b1; bus.D = '0;
      #5;
      total++;
      if (bus.Q !== '0) begin
         bad++; $display("FAIL reset_q: got %0d want 0", bus.Q);
      end
      total++;
      if (bus.Bo !== 1'b1) begin
         bad++; $display("FAIL reset_bo_ctt1: got %b want 1", bus.Bo);
      end
      bus.CTT = 1'b0;
      #1;
      total++;
      if (bus.Bo !== 1'b0) begin
         bad++; $display("FAIL reset_bo_ctt0: got %b want 0", bus.Bo);
      end
      @(negedge cp);
      cr = 1'b0;
      m = 0; lo_m = 0; hi_m = 0;
      // Preset 4'b1010, then reset asynchronously between edges.
      bus.LD = 1'b0; bus.D = 4'b1010; bus.CTT = 1'b1;
      step();
      exp_q = 4'(m);
      total++;
      if (bus.Q !== exp_q || exp_q !== 4'd10) begin
         bad++; $display("FAIL preset: got %0d want 10", bus.Q);
      end
      bus.LD = 1'b1; bus.CTP = 1'b1;
      #5;
      cr = 1'b1;
      #1;
      total++;
      if (bus.Q !== '0) begin
         bad++; $display("FAIL async_reset_q: got %0d want 0", bus.Q);
      end
      total++;
      if (bus.Bo !== bus.CTT) begin
         bad++; $display("FAIL async_reset_bo: got %b want %b", bus.Bo, bus.CTT);
      end
      #24;
      cr = 1'b0;
      m = 0;
      // Counting resumes from zero on the first edge after CR falls.
      step();
      exp_q = 4'(m);
      total++;
      if (bus.Q !== exp_q) begin
         bad++; $display("FAIL resume_after_reset: got %0d want %0d", bus.Q, exp_q);
      end
   endtask

   task automatic test_load_priority();
      logic [W-1:0] exp_q;
      bus.D = 4'b1100; bus.LD = 1'b0; bus.CTP = 1'b1; bus.CTT = 1'b1;
      step();
      total++;
      if (bus.Q !== 4'd12) begin
         bad++; $display("FAIL load_wins: got %0d want 12", bus.Q);
      end
      bus.LD = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_q = 4'(11 - i);
         total++;
         if (bus.Q !== exp_q) begin
            bad++; $display("FAIL count_down[%0d]: got %0d want %0d", i, bus.Q, exp_q);
         end
         total++;
         if (bus.Bo !== (exp_q == 0)) begin
            bad++; $display("FAIL count_bo[%0d]: got %b want %b", i, bus.Bo, exp_q == 0);
         end
      end
   endtask

   task automatic test_wrap_borrow();
      logic [W-1:0] exp_q;
      bus.D = 4'd1; bus.LD = 1'b0;
      step();
      bus.LD = 1'b1; bus.D = 4'd7;
      step();
      total++;
      if (bus.Q !== 4'd0 || bus.Bo !== 1'b1) begin
         bad++; $display("FAIL wrap_zero: got q=%0d bo=%b want q=0 bo=1", bus.Q, bus.Bo);
      end
      step();
`ifdef MY_DOWN_COUNTER_AUTO_RELOAD_EN
      exp_q = 4'd7;
`else
      exp_q = 4'd15;
`endif
      total++;
      if (bus.Q !== exp_q || bus.Bo !== 1'b0) begin
         bad++; $display("FAIL wrap_next: got q=%0d bo=%b want q=%0d bo=0", bus.Q, bus.Bo, exp_q);
      end
      // Stop at zero with CTT low: no borrow, Q holds.
      bus.D = 4'd0; bus.LD = 1'b0;
      step();
      bus.LD = 1'b1; bus.CTT = 1'b0;
      #1;
      total++;
      if (bus.Bo !== 1'b0) begin
         bad++; $display("FAIL ctt0_bo: got %b want 0", bus.Bo);
      end
      step();
      total++;
      if (bus.Q !== 4'd0) begin
         bad++; $display("FAIL ctt0_hold: got %0d want 0", bus.Q);
      end
   endtask

   task automatic test_enable_gating();
      bus.D = 4'd9; bus.LD = 1'b0; bus.CTT = 1'b1;
      step();
      bus.LD = 1'b1; bus.CTP = 1'b0; bus.CTT = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (bus.Q !== 4'(m) || m != 9) begin
            bad++; $display("FAIL ctp0_hold[%0d]: got %0d want 9", i, bus.Q);
         end
         total++;
         if (bus.Bo !== 1'b0) begin
            bad++; $display("FAIL ctp0_bo[%0d]: got %b want 0", i, bus.Bo);
         end
      end
      bus.CTP = 1'b1; bus.CTT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (bus.Q !== 4'd9 || bus.Bo !== 1'b0) begin
            bad++; $display("FAIL ctt0_gate[%0d]: got q=%0d bo=%b want q=9 bo=0", i, bus.Q, bus.Bo);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q;
      for (int i = 0; i < 300; i++) begin
         bus.LD  = ($urandom_range(0, 7) != 0);
         bus.CTP = ($urandom_range(0, 3) != 0);
         bus.CTT = ($urandom_range(0, 3) != 0);
         bus.D   = 4'($urandom_range(0, M - 1));
         step();
         exp_q = 4'(m);
         total++;
         if (bus.Q !== exp_q) begin
            bad++; $display("FAIL random_q[%0d]: got %0d want %0d", i, bus.Q, exp_q);
         end
         bus.CTT = $urandom_range(0, 1);
         #1;
         total++;
         if (bus.Bo !== (bus.CTT && m == 0)) begin
            bad++; $display("FAIL random_bo[%0d]: got %b want %b", i, bus.Bo, bus.CTT && m == 0);
         end
      end
   endtask

`ifdef MY_DOWN_COUNTER_AUTO_RELOAD_EN
   task automatic test_auto_reload();
      int exp_seq[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
      bus.D = 4'd3; bus.LD = 1'b0; bus.CTP = 1'b1; bus.CTT = 1'b1;
      step();
      bus.LD = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) step();
         total++;
         if (bus.Q !== 4'(exp_seq[i]) || bus.Bo !== (exp_seq[i] == 0)) begin
            bad++; $display("FAIL auto_reload[%0d]: got q=%0d bo=%b want q=%0d bo=%b", i,
                            bus.Q, bus.Bo, exp_seq[i], exp_seq[i] == 0);
         end
      end
   endtask
`endif

   task automatic test_cascade();
      int got;
      int want;
      bus_lo.D = 4'h0; bus_hi.D = 4'h1;
      bus_lo.LD = 1'b0; bus_hi.LD = 1'b0;
      bus_lo.CTP = 1'b1; bus_hi.CTP = 1'b1; bus_lo.CTT = 1'b1;
      step();
      got = {bus_hi.Q, bus_lo.Q};
      total++;
      if (got != 8'h10) begin
         bad++; $display("FAIL cascade_load: got %02h want 10", got);
      end
      bus_lo.LD = 1'b0 ^ 1'b1; bus_hi.LD = 1'b1;
      for (int i = 0; i < 24; i++) begin
         step();
         got  = {bus_hi.Q, bus_lo.Q};
         want = hi_m * 16 + lo_m;
`ifndef MY_DOWN_COUNTER_AUTO_RELOAD_EN
         // Without reload the pair is a plain 8-bit down counter from 8'h10.
         want = (16'h10 + 256 * 4 - (i + 1)) % 256;
`endif
         total++;
         if (got != want) begin
            bad++; $display("FAIL cascade_q[%0d]: got %02h want %02h", i, got, want);
         end
         total++;
         if (bus_hi.Bo !== (want == 0)) begin
            bad++; $display("FAIL cascade_bo[%0d]: got %b want %b", i, bus_hi.Bo, want == 0);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      cr = 1'b1;
      m = 0; lo_m = 0; hi_m = 0;
      bus_lo.LD = 1'b1; bus_lo.CTP = 1'b0; bus_lo.CTT = 1'b0; bus_lo.D = '0;
      bus_hi.LD = 1'b1; bus_hi.CTP = 1'b0; bus_hi.D = '0;
      test_reset();
      test_load_priority();
      test_wrap_borrow();
      test_enable_gating();
`ifdef MY_DOWN_COUNTER_AUTO_RELOAD_EN
      test_auto_reload();
`endif
      test_random();
      test_cascade();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
